// File: rtl/dcache_wt.sv
// Direct-mapped, write-through, no-write-allocate data cache between the M stage and data RAM.
// Optional hit/miss counters are enabled by defining DCACHE_STATS_EN.
module dcache_wt #(
  parameter int unsigned INDEX_BITS = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_en,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        ram_en,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  input  logic        ram_ready
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  localparam int unsigned TAG_BITS = 32 - 2 - INDEX_BITS;
  localparam int unsigned LINES    = 2 ** INDEX_BITS;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RD_MISS = 2'd1;
  localparam logic [1:0] WR_THRU = 2'd2;

  logic [1:0]          state;
  logic [1:0]          stateNext;
  logic [LINES-1:0]    validQ;
  logic [TAG_BITS-1:0] tagMem  [LINES];
  logic [31:0]         dataMem [LINES];
  logic [29:0]         reqWord;
  logic [31:0]         reqData;

  logic [INDEX_BITS-1:0] cpuIdx;
  logic [TAG_BITS-1:0]   cpuTag;
  logic [INDEX_BITS-1:0] reqIdx;
  logic [TAG_BITS-1:0]   reqTag;
  logic                  hit;
  logic                  reqHit;
  logic                  latchReq;
  logic                  fillLine;
  logic                  updateLine;
  logic                  countHit;
  logic                  countMiss;
  logic                  unusedAddrLsbs;

  assign cpuIdx         = cpu_addr[INDEX_BITS+1:2];
  assign cpuTag         = cpu_addr[31:INDEX_BITS+2];
  assign reqIdx         = reqWord[INDEX_BITS-1:0];
  assign reqTag         = reqWord[29:INDEX_BITS];
  assign unusedAddrLsbs = ^cpu_addr[1:0];

  assign hit    = cpu_en & validQ[cpuIdx] & (tagMem[cpuIdx] == cpuTag);
  assign reqHit = validQ[reqIdx] & (tagMem[reqIdx] == reqTag);

  assign ram_addr  = {reqWord, 2'b00};
  assign ram_wdata = reqData;

  // Next state, stall/read-data muxing and array write strobes
  always_comb begin
    stateNext  = state;
    cpu_stall  = 1'b0;
    cpu_rdata  = 32'd0;
    ram_en     = 1'b0;
    ram_we     = 1'b0;
    latchReq   = 1'b0;
    fillLine   = 1'b0;
    updateLine = 1'b0;
    countHit   = 1'b0;
    countMiss  = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_en) begin
          if (cpu_we) begin
            cpu_stall = 1'b1;
            latchReq  = 1'b1;
            stateNext = WR_THRU;
          end else if (hit) begin
            cpu_rdata = dataMem[cpuIdx];
            countHit  = 1'b1;
          end else begin
            cpu_stall = 1'b1;
            latchReq  = 1'b1;
            countMiss = 1'b1;
            stateNext = RD_MISS;
          end
        end
      end
      RD_MISS: begin
        ram_en = 1'b1;
        if (ram_ready) begin
          cpu_rdata = ram_rdata;
          fillLine  = 1'b1;
          stateNext = IDLE;
        end else begin
          cpu_stall = 1'b1;
        end
      end
      WR_THRU: begin
        ram_en = 1'b1;
        ram_we = 1'b1;
        if (ram_ready) begin
          updateLine = reqHit;
          stateNext  = IDLE;
        end else begin
          cpu_stall = 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // State, valid bits and latched request
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      validQ  <= '0;
      reqWord <= 30'd0;
      reqData <= 32'd0;
    end else begin
      state <= stateNext;
      if (latchReq) begin
        reqWord <= cpu_addr[31:2];
        reqData <= cpu_wdata;
      end
      if (fillLine) validQ[reqIdx] <= 1'b1;
    end
  end

  // Tag/data arrays are not reset; reset suppresses any pending write
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (fillLine) begin
        tagMem[reqIdx]  <= reqTag;
        dataMem[reqIdx] <= ram_rdata;
      end
      if (updateLine) dataMem[reqIdx] <= reqData;
    end
  end

`ifdef DCACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt  <= 32'd0;
      miss_cnt <= 32'd0;
    end else begin
      if (countHit)  hit_cnt  <= hit_cnt + 32'd1;
      if (countMiss) miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_wt.sv
// Directed self-checking bench for dcache_wt; the RAM side is driven per access with a chosen latency.
module tb_dcache_wt;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_en, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        ram_en, ram_we;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;
  logic        ram_ready;
`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dcache_wt dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_en    (cpu_en),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .ram_ready (ram_ready)
`ifdef DCACHE_STATS_EN
    ,
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One CPU request; the RAM answers after 'lat' wait cycles in the miss/write state
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input int lat, input logic [31:0] rdata,
                        output int stalls, output logic [31:0] rdOut, output logic sawRam,
                        output logic sawWe, output logic [31:0] sawAddr,
                        output logic [31:0] sawWdata, output logic timedOut);
    int waited;
    bit done;
    waited = 0; done = 0;
    stalls = 0; rdOut = '0; sawRam = 0; sawWe = 0; sawAddr = '0; sawWdata = '0; timedOut = 1;
    cpu_en = 1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    for (int c = 0; c < 32 && !done; c++) begin
      ram_ready = 0; ram_rdata = '0;
      if (ram_en) begin
        sawRam = 1; sawWe = ram_we; sawAddr = ram_addr; sawWdata = ram_wdata;
        if (waited == lat) begin ram_ready = 1; ram_rdata = rdata; end
        else waited++;
      end
      #1;
      if (cpu_stall) stalls++;
      else begin rdOut = cpu_rdata; done = 1; timedOut = 0; end
      @(posedge clk); #1;
    end
    cpu_en = 0; cpu_we = 0; ram_ready = 0; ram_rdata = '0;
  endtask

  task automatic doReset();
    rst = 1; cpu_en = 0; cpu_we = 0; ram_ready = 0;
    repeat (2) @(posedge clk);
    #1; rst = 0;
  endtask

  initial begin
    int st;
    logic [31:0] rd, sa, sw;
    logic sr, swe, to;

    rst = 1; cpu_en = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    ram_rdata = '0; ram_ready = 0;
    doReset();

    #1;
    check("rst_stall", 32'(cpu_stall), 32'd0);
    check("rst_ram_en", 32'(ram_en), 32'd0);
    check("rst_ram_we", 32'(ram_we), 32'd0);
    check("rst_ram_addr", ram_addr, 32'd0);
    check("rst_ram_wdata", ram_wdata, 32'd0);
    check("rst_rdata", cpu_rdata, 32'd0);
    @(posedge clk); #1;

    // Cold load miss, RAM answers on the third cycle of the miss
    access(0, 32'h40, 0, 2, 32'hDEADBEEF, st, rd, sr, swe, sa, sw, to);
    check("miss40_timeout", 32'(to), 32'd0);
    check("miss40_stalls", 32'(st), 32'd3);
    check("miss40_rdata", rd, 32'hDEADBEEF);
    check("miss40_ram_addr", sa, 32'h40);
    check("miss40_ram_we", 32'(swe), 32'd0);
    #1;
    check("post_miss_ram_en", 32'(ram_en), 32'd0);
    check("post_miss_rdata", cpu_rdata, 32'd0);
    @(posedge clk); #1;

    access(0, 32'h40, 0, 0, 32'hFFFFFFFF, st, rd, sr, swe, sa, sw, to);
    check("hit40_stalls", 32'(st), 32'd0);
    check("hit40_rdata", rd, 32'hDEADBEEF);
    check("hit40_no_ram", 32'(sr), 32'd0);

    // Store hit: write through and update the line
    access(1, 32'h40, 32'h12345678, 1, 0, st, rd, sr, swe, sa, sw, to);
    check("st40_timeout", 32'(to), 32'd0);
    check("st40_stalls", 32'(st), 32'd2);
    check("st40_ram_we", 32'(swe), 32'd1);
    check("st40_ram_addr", sa, 32'h40);
    check("st40_ram_wdata", sw, 32'h12345678);
    access(0, 32'h40, 0, 0, 32'hFFFFFFFF, st, rd, sr, swe, sa, sw, to);
    check("hit40b_stalls", 32'(st), 32'd0);
    check("hit40b_rdata", rd, 32'h12345678);

    // Store miss does not allocate
    access(1, 32'h80, 32'hCAFEF00D, 0, 0, st, rd, sr, swe, sa, sw, to);
    check("st80_stalls", 32'(st), 32'd1);
    check("st80_ram_addr", sa, 32'h80);
    check("st80_ram_we", 32'(swe), 32'd1);
    access(0, 32'h80, 0, 0, 32'hCAFEF00D, st, rd, sr, swe, sa, sw, to);
    check("ld80_miss_stalls", 32'(st), 32'd1);
    check("ld80_miss_ram", 32'(sr), 32'd1);
    check("ld80_rdata", rd, 32'hCAFEF00D);
    access(0, 32'h80, 0, 0, 32'hFFFFFFFF, st, rd, sr, swe, sa, sw, to);
    check("ld80_hit_stalls", 32'(st), 32'd0);

    // Conflict on index 16: 0x40 and 0x140 evict each other
    access(0, 32'h140, 0, 0, 32'h0BADF00D, st, rd, sr, swe, sa, sw, to);
    check("ld140_stalls", 32'(st), 32'd1);
    check("ld140_rdata", rd, 32'h0BADF00D);
    access(0, 32'h40, 0, 0, 32'h12345678, st, rd, sr, swe, sa, sw, to);
    check("ld40_evicted_stalls", 32'(st), 32'd1);
    check("ld40_evicted_rdata", rd, 32'h12345678);
    access(0, 32'h140, 0, 3, 32'h0BADF00D, st, rd, sr, swe, sa, sw, to);
    check("ld140b_stalls", 32'(st), 32'd4);
    access(0, 32'h140, 0, 0, 32'hFFFFFFFF, st, rd, sr, swe, sa, sw, to);
    check("ld140_hit_stalls", 32'(st), 32'd0);
    check("ld140_hit_rdata", rd, 32'h0BADF00D);

    // Reset while a load miss is outstanding, with ram_ready in the same cycle
    cpu_en = 1; cpu_we = 0; cpu_addr = 32'h200;
    #1;
    check("rmid_idle_stall", 32'(cpu_stall), 32'd1);
    @(posedge clk); #1;
    check("rmid_ram_en", 32'(ram_en), 32'd1);
    check("rmid_ram_addr", ram_addr, 32'h200);
    rst = 1; ram_ready = 1; ram_rdata = 32'h55AA55AA;
    @(posedge clk); #1;
    rst = 0; cpu_en = 0;
    #1;
    check("rmid_after_ram_en", 32'(ram_en), 32'd0);
    check("rmid_after_stall", 32'(cpu_stall), 32'd0);
    check("rmid_late_rdata", cpu_rdata, 32'd0);
    @(posedge clk); #1;
    ram_ready = 0; ram_rdata = '0;
    check("rmid_still_idle", 32'(ram_en), 32'd0);
    access(0, 32'h200, 0, 0, 32'h11112222, st, rd, sr, swe, sa, sw, to);
    check("rmid_ld200_stalls", 32'(st), 32'd1);
    check("rmid_ld200_rdata", rd, 32'h11112222);
    access(0, 32'h40, 0, 0, 32'h12345678, st, rd, sr, swe, sa, sw, to);
    check("rmid_ld40_stalls", 32'(st), 32'd1);

`ifdef DCACHE_STATS_EN
    doReset();
    #1;
    check("stats_rst_hit", hit_cnt, 32'd0);
    check("stats_rst_miss", miss_cnt, 32'd0);
    @(posedge clk); #1;
    access(0, 32'h300, 0, 0, 32'hA5A5A5A5, st, rd, sr, swe, sa, sw, to);
    for (int i = 0; i < 4; i++)
      access(0, 32'h300, 0, 0, 32'hFFFFFFFF, st, rd, sr, swe, sa, sw, to);
    access(1, 32'h300, 32'h1, 0, 0, st, rd, sr, swe, sa, sw, to);
    access(1, 32'h304, 32'h2, 0, 0, st, rd, sr, swe, sa, sw, to);
    check("stats_hit", hit_cnt, 32'd4);
    check("stats_miss", miss_cnt, 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
